// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program memory: FSM encoding, NOP word and the
// instruction-set constants that loaders and the fetch path agree on.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Byte index width inside a word; covers up to four bytes (DATA_W = 32).
    localparam int IDX_W = 2;

    // The all-zero word is the NOP encoding; narrower builds take its low bits.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Opcodes live in the top byte of an instruction word.
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDI = 8'hD0;
    localparam logic [7:0] OP_ADD = 8'hD6;
    localparam logic [7:0] OP_JMP = 8'hE7;

    localparam int         NUM_REGS = 16;
    localparam logic [3:0] REG_ZERO = 4'h0;
    localparam logic [3:0] REG_SP   = 4'hF;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/prog_mem_packer.sv
// Byte-to-word assembler: shifts loader bytes in MSB-first and strobes
// word_done on the byte that completes a word.
module prog_mem_packer
    import prog_mem_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic [IDX_W-1:0]  index,
    output logic              word_done
);

    localparam int               BYTES    = bytes_per_word(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [DATA_W-1:0] shifted;

    generate
        if (DATA_W == 8) begin : g_single
            assign shifted = byte_in;
        end else begin : g_multi
            assign shifted = {word[DATA_W-9:0], byte_in};
        end
    endgenerate

    assign word_done = accept && (index == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word  <= '0;
            index <= '0;
        end else if (accept) begin
            word  <= shifted;
            index <= word_done ? '0 : index + 1'b1;
        end
    end

endmodule

// File: rtl/prog_mem.sv
// Loadable program memory with registered fetch port and byte-stream loader.
// Optional feature macro: PROG_MEM_CHECKSUM_EN adds an XOR checksum output.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    input  logic              load_start,
    input  logic              load_end,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_err
`ifdef PROG_MEM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int                DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [DATA_W-1:0] NOP        = NOP_WORD[DATA_W-1:0];

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   count_next;
    logic              err_next;
    logic              end_pending;
    logic              pend_next;
    logic              do_write;
    logic              packer_clear;
    logic              accept;
    logic              word_done;
    logic              busy_next;
    logic [DATA_W-1:0] word;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] mem [DEPTH];

    assign ld_ready  = (state == COLLECT);
    assign ld_busy   = (state == COLLECT) || (state == COMMIT);
    assign accept    = ld_valid && ld_ready && !load_start;
    assign busy_next = (state_next == COLLECT) || (state_next == COMMIT);

    prog_mem_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (packer_clear),
        .accept    (accept),
        .byte_in   (ld_byte),
        .word      (word),
        .index     (index),
        .word_done (word_done)
    );

    // A load_end that arrives with or during a completing word is parked in
    // end_pending and honoured once the commit cycle has written the word.
    always_comb begin
        state_next   = state;
        count_next   = ld_count;
        err_next     = ld_err;
        pend_next    = end_pending;
        do_write     = 1'b0;
        packer_clear = 1'b0;
        if (load_start) begin
            state_next   = COLLECT;
            count_next   = '0;
            err_next     = 1'b0;
            pend_next    = 1'b0;
            packer_clear = 1'b1;
        end else begin
            case (state)
                COLLECT: begin
                    if (word_done) begin
                        state_next = COMMIT;
                        if (load_end) pend_next = 1'b1;
                    end else if (load_end) begin
                        state_next   = DONE;
                        packer_clear = 1'b1;
                        if (accept || index != '0) err_next = 1'b1;
                    end
                end
                COMMIT: begin
                    do_write   = 1'b1;
                    count_next = ld_count + 1'b1;
                    pend_next  = 1'b0;
                    if (count_next == FULL_COUNT || end_pending || load_end)
                        state_next = DONE;
                    else
                        state_next = COLLECT;
                end
                DONE: begin
                    if (ld_valid && ld_count == FULL_COUNT) err_next = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ld_count    <= '0;
            ld_err      <= 1'b0;
            end_pending <= 1'b0;
        end else begin
            state       <= state_next;
            ld_count    <= count_next;
            ld_err      <= err_next;
            end_pending <= pend_next;
        end
    end

    // The array is deliberately left out of reset; ld_count gates every read.
    always_ff @(posedge clk) begin
        if (do_write && !reset) mem[ld_count[ADDR_W-1:0]] <= word;
    end

    // Busy is judged on the next state so data reads NOP on every busy cycle.
    always_ff @(posedge clk) begin
        if (reset || busy_next)
            data <= NOP;
        else if ({1'b0, addr} < ld_count)
            data <= mem[addr];
        else
            data <= NOP;
    end

`ifdef PROG_MEM_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || load_start)
            checksum <= '0;
        else if (do_write)
            checksum <= checksum ^ word;
    end
`endif

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: directed load/fetch vectors plus corner
// sequences; a second instance with ADDR_W=2 exercises the memory-full path.
module tb_prog_mem;

    logic        clk;
    logic        reset;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        load_start;
    logic        load_end;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic        ld_busy;
    logic [8:0]  ld_count;
    logic        ld_err;

    logic [1:0]  s_addr;
    logic [15:0] s_data;
    logic        s_load_start;
    logic        s_load_end;
    logic        s_valid;
    logic [7:0]  s_byte;
    logic        s_ready;
    logic        s_busy;
    logic [2:0]  s_count;
    logic        s_err;

`ifdef PROG_MEM_CHECKSUM_EN
    logic [15:0] checksum;
    logic [15:0] s_checksum;
`endif

    int checks;
    int failures;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] exp;
    } fetch_vec_t;

    fetch_vec_t  load_reads[6];
    fetch_vec_t  stream_reads[3];
    logic        ready_pattern[9];
    logic [7:0]  stream_bytes[6];
    logic [7:0]  small_bytes[8];

    prog_mem #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .data       (data),
        .load_start (load_start),
        .load_end   (load_end),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_ready   (ld_ready),
        .ld_busy    (ld_busy),
        .ld_count   (ld_count),
        .ld_err     (ld_err)
`ifdef PROG_MEM_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    prog_mem #(.DATA_W(16), .ADDR_W(2)) dut_small (
        .clk        (clk),
        .reset      (reset),
        .addr       (s_addr),
        .data       (s_data),
        .load_start (s_load_start),
        .load_end   (s_load_end),
        .ld_valid   (s_valid),
        .ld_byte    (s_byte),
        .ld_ready   (s_ready),
        .ld_busy    (s_busy),
        .ld_count   (s_count),
        .ld_err     (s_err)
`ifdef PROG_MEM_CHECKSUM_EN
        ,
        .checksum   (s_checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Offers one byte and waits (bounded) until the DUT accepts it.
    task automatic apply_stimulus(input logic [7:0] b);
        bit accepted;
        accepted = 1'b0;
        ld_valid = 1'b1;
        ld_byte  = b;
        for (int n = 0; n < 10; n++) begin
            if (ld_ready) begin
                tick();
                accepted = 1'b1;
                break;
            end
            tick();
        end
        ld_valid = 1'b0;
        if (!accepted) check_output("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_check(input logic [7:0] a, input logic [15:0] exp,
                              input string name);
        addr = a;
        tick();
        check_output(name, {16'h0, data}, {16'h0, exp});
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic pulse_end();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
    endtask

    initial begin
        int k;
        logic rdy;

        checks   = 0;
        failures = 0;

        load_reads[0] = '{8'd0,   16'hD000};
        load_reads[1] = '{8'd1,   16'hD600};
        load_reads[2] = '{8'd2,   16'hE702};
        load_reads[3] = '{8'd3,   16'h0000};
        load_reads[4] = '{8'd255, 16'h0000};
        load_reads[5] = '{8'd2,   16'hE702};

        stream_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        stream_reads[0] = '{8'd0, 16'h1122};
        stream_reads[1] = '{8'd1, 16'h3344};
        stream_reads[2] = '{8'd2, 16'h5566};
        ready_pattern = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        small_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

        reset        = 1'b1;
        addr         = '0;
        load_start   = 1'b0;
        load_end     = 1'b0;
        ld_valid     = 1'b0;
        ld_byte      = '0;
        s_addr       = '0;
        s_load_start = 1'b0;
        s_load_end   = 1'b0;
        s_valid      = 1'b0;
        s_byte       = '0;

        // Reset state and empty-memory reads
        tick();
        tick();
        reset = 1'b0;
        check_output("reset_count", {23'h0, ld_count}, 32'd0);
        check_output("reset_err",   {31'h0, ld_err},   32'd0);
        check_output("reset_busy",  {31'h0, ld_busy},  32'd0);
        check_output("reset_ready", {31'h0, ld_ready}, 32'd0);
        for (int i = 0; i < 4; i++) read_check(8'(i), 16'h0000, "reset_read");

        // Three-word load, load_end arriving during the last commit
        $display("[TB] three-word load");
        addr = 8'd0;
        pulse_start();
        check_output("load_busy", {31'h0, ld_busy}, 32'd1);
        apply_stimulus(8'hD0);
        apply_stimulus(8'h00);
        apply_stimulus(8'hD6);
        apply_stimulus(8'h00);
        check_output("busy_read_nop", {16'h0, data}, 32'd0);
        apply_stimulus(8'hE7);
        apply_stimulus(8'h02);
        pulse_end();
        check_output("load3_count", {23'h0, ld_count}, 32'd3);
        check_output("load3_err",   {31'h0, ld_err},   32'd0);
        check_output("load3_busy",  {31'h0, ld_busy},  32'd0);
        for (int i = 0; i < 6; i++)
            read_check(load_reads[i].addr, load_reads[i].exp, "load3_read");

        // Continuous ld_valid: ready must drop one cycle after every second byte
        $display("[TB] streaming load");
        pulse_start();
        k = 0;
        ld_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            ld_byte = (k < 6) ? stream_bytes[k] : 8'h00;
            rdy = ld_ready;
            check_output("ready_pattern", {31'h0, rdy}, {31'h0, ready_pattern[c]});
            tick();
            if (rdy) k++;
        end
        ld_valid = 1'b0;
        pulse_end();
        check_output("stream_count", {23'h0, ld_count}, 32'd3);
        check_output("stream_err",   {31'h0, ld_err},   32'd0);
        for (int i = 0; i < 3; i++)
            read_check(stream_reads[i].addr, stream_reads[i].exp, "stream_read");

        // load_end after a partial word
        $display("[TB] partial word discard");
        pulse_start();
        apply_stimulus(8'h12);
        apply_stimulus(8'h34);
        apply_stimulus(8'h56);
        pulse_end();
        check_output("partial_count", {23'h0, ld_count}, 32'd1);
        check_output("partial_err",   {31'h0, ld_err},   32'd1);
        check_output("partial_busy",  {31'h0, ld_busy},  32'd0);
        read_check(8'd0, 16'h1234, "partial_read0");
        read_check(8'd1, 16'h0000, "partial_read1");

        // load_end coinciding with the word-completing byte
        $display("[TB] load_end with final byte");
        pulse_start();
        apply_stimulus(8'hAB);
        ld_valid = 1'b1;
        ld_byte  = 8'hCD;
        load_end = 1'b1;
        tick();
        ld_valid = 1'b0;
        load_end = 1'b0;
        check_output("coinc_busy_commit", {31'h0, ld_busy}, 32'd1);
        tick();
        check_output("coinc_count", {23'h0, ld_count}, 32'd1);
        check_output("coinc_err",   {31'h0, ld_err},   32'd0);
        check_output("coinc_busy",  {31'h0, ld_busy},  32'd0);
        read_check(8'd0, 16'hABCD, "coinc_read0");

        // Reset in mid-load, then a fresh one-word load
        $display("[TB] reset mid-load");
        pulse_start();
        apply_stimulus(8'h77);
        apply_stimulus(8'h88);
        apply_stimulus(8'h99);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("abort_count", {23'h0, ld_count}, 32'd0);
        check_output("abort_busy",  {31'h0, ld_busy},  32'd0);
        read_check(8'd0, 16'h0000, "abort_read0");
        pulse_start();
        apply_stimulus(8'hA5);
        apply_stimulus(8'hA5);
        pulse_end();
        check_output("reload_count", {23'h0, ld_count}, 32'd1);
        read_check(8'd0, 16'hA5A5, "reload_read0");
`ifdef PROG_MEM_CHECKSUM_EN
        check_output("reload_checksum", {16'h0, checksum}, 32'h0000_A5A5);
`endif

        // Small instance: fill all four words, then offer one extra byte
        $display("[TB] memory full on ADDR_W=2 instance");
        s_load_start = 1'b1;
        tick();
        s_load_start = 1'b0;
        k = 0;
        for (int c = 0; c < 30; c++) begin
            if (k < 8) begin
                s_valid = 1'b1;
                s_byte  = small_bytes[k];
            end else begin
                s_valid = 1'b0;
            end
            rdy = s_ready && s_valid;
            tick();
            if (rdy) k++;
        end
        s_valid = 1'b0;
        check_output("small_accepted", 32'(k), 32'd8);
        check_output("small_full_count", {29'h0, s_count}, 32'd4);
        check_output("small_full_err",   {31'h0, s_err},   32'd0);
        check_output("small_full_busy",  {31'h0, s_busy},  32'd0);
        s_valid = 1'b1;
        s_byte  = 8'hFF;
        tick();
        s_valid = 1'b0;
        check_output("small_over_err",   {31'h0, s_err},   32'd1);
        check_output("small_over_count", {29'h0, s_count}, 32'd4);
        check_output("small_over_busy",  {31'h0, s_busy},  32'd0);
        s_addr = 2'd0;
        tick();
        check_output("small_read0", {16'h0, s_data}, 32'h0000_0102);
        s_addr = 2'd3;
        tick();
        check_output("small_read3", {16'h0, s_data}, 32'h0000_0708);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the instruction word width; legal values are multiples of 8 from 8 to 32.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning the address width; depth is 2**ADDR_W words.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port addr, input, ADDR_W bits: CPU fetch address.
REQ-006 Port data, output, DATA_W bits: registered fetch word.
REQ-007 Port load_start, input, 1 bit: one-cycle pulse that begins a program load.
REQ-008 Port load_end, input, 1 bit: one-cycle pulse that ends a program load.
REQ-009 Port ld_valid, input, 1 bit: loader byte valid.
REQ-010 Port ld_byte, input, 8 bits: loader byte.
REQ-011 Port ld_ready, output, 1 bit: a byte is accepted when ld_valid and ld_ready are both high.
REQ-012 Port ld_busy, output, 1 bit: a load is in progress.
REQ-013 Port ld_count, output, ADDR_W+1 bits: number of words loaded.
REQ-014 Port ld_err, output, 1 bit: sticky overflow or partial-word error.

Function
REQ-015 The FSM SHALL have the states IDLE, COLLECT, COMMIT and DONE; it leaves reset in IDLE.
REQ-016 load_start in any state SHALL go to COLLECT, clear ld_count, the byte index and ld_err, and abandon any partial word.
REQ-017 In COLLECT, ld_ready SHALL be 1 and each accepted byte is shifted into the word MSB-first; the first byte fills data bits [DATA_W-1:DATA_W-8].
REQ-018 After DATA_W/8 accepted bytes the FSM SHALL go to COMMIT, in which ld_ready is 0.
REQ-019 In COMMIT, the FSM SHALL write the word at address ld_count[ADDR_W-1:0], increment ld_count, and return to COLLECT one cycle later.
REQ-020 When ld_count reaches 2**ADDR_W, the FSM SHALL go to DONE.
REQ-021 A byte offered after the memory is full SHALL set ld_err and SHALL NOT be written; no wrap-around occurs.
REQ-022 load_end in COLLECT SHALL go to DONE; if a partial word is pending, it is discarded and ld_err is set.
REQ-023 load_end during COMMIT SHALL take effect after the commit completes.
REQ-024 When load_end and an accepted byte coincide, the byte SHALL be accepted first and then load_end is applied.
REQ-025 DONE and IDLE are equivalent for fetch; the only difference is that DONE reports ld_busy=0 after a load.
REQ-026 ld_busy SHALL be 1 in COLLECT and COMMIT only.
REQ-027 Fetch SHALL have 1-cycle latency: data(t+1) = mem[addr(t)] if addr(t) < ld_count, else 0.
REQ-028 While ld_busy is 1, data SHALL be 0 (the NOP encoding), whatever the address.
REQ-029 A fetch to the address being written in COMMIT SHALL return 0 on that cycle, because the block is busy.

Reset
REQ-030 Reset SHALL force the state to IDLE and data, ld_ready, ld_busy, ld_count, ld_err and the byte index to 0.
REQ-031 Reset SHALL NOT clear the memory array; the array is unreachable afterwards because ld_count is 0.
REQ-032 Reset asserted mid-load SHALL abort the load, and all reads SHALL return 0 from then on.

Configuration
REQ-033 Macro PROG_MEM_CHECKSUM_EN defined SHALL add an output port checksum, DATA_W bits.
REQ-034 With the macro, checksum is cleared by reset and by load_start and is XOR-accumulated with each committed word in COMMIT.
REQ-035 Without the macro, there SHALL be no checksum port or logic, and all other behaviour is identical.

Structure
REQ-036 The FSM state encoding and the NOP word constant SHALL live in the shared package prog_mem_pkg, next to the opcode and register constants.
REQ-037 The byte-to-word assembler (shift register, byte index, word-complete strobe) SHALL be the sub-module prog_mem_packer; the array, FSM and fetch logic stay in prog_mem.

Verification
REQ-038 Scenario: after reset, read addr 0..3 -> data is 0 on every read; ld_count=0; ld_err=0.
REQ-039 Scenario: load_start, then bytes D0 00 D6 00 E7 02, then load_end -> ld_count=3; mem[0..2]=D000, D600, E702; after load_end, read addr 2 -> data=E702 one cycle later; addr 3 -> 0.
REQ-040 Scenario: ld_valid held high continuously -> ld_ready drops for exactly one cycle after every second byte; no byte is lost or duplicated.
REQ-041 Scenario: ADDR_W=2; load 4 words then one extra byte -> ld_count=4, ld_err=1, state DONE, mem[0] unchanged.
REQ-042 Scenario: load_end after 3 bytes (DATA_W=16) -> ld_count=1, ld_err=1, only word 0 readable.
REQ-043 Scenario: reset asserted mid-load, then a new load of 1 word A5A5 -> data=A5A5 at addr 0; with PROG_MEM_CHECKSUM_EN, checksum=A5A5.
